dma_req_arbiter: RTL

- Shares one external DMA burst-request channel (DMACBREQ/DMACCLR pair) among N peripheral DMA requesters (ADC/DAC `dma_req` level outputs) on the APB peripheral bus.
- Arbitrates round-robin, tracks the active grant, and returns the DMAC clear pulse only to the granted requester.
- Recovers from a missing DMAC clear via a timeout.
- Software configures and monitors it through a 4 KB APB register window.

---
 rtl/dma_req_arbiter_pkg.sv | 23 ++
 rtl/dma_req_arbiter_if.sv | 30 +++
 rtl/dma_req_arbiter_rr_pick.sv | 32 +++
 rtl/dma_req_arbiter.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/dma_req_arbiter_pkg.sv
// Shared definitions for the DMA request arbiter: register map, STAT/CTRL
// bit positions and the grant FSM encoding.
package dma_req_arbiter_pkg;

  localparam logic [11:0] ADDR_CTRL     = 12'h000;
  localparam logic [11:0] ADDR_STAT     = 12'h004;
  localparam logic [11:0] ADDR_XFER_CNT = 12'h008;

  localparam int CTRL_EN_BIT   = 31;
  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_TMO_BIT  = 1;
  localparam int STAT_GIDX_LSB = 8;
  localparam int STAT_EIDX_LSB = 16;
  localparam int XFER_W        = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_CLR   = 2'd2,
    ST_GAP   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/dma_req_arbiter_if.sv
// APB slave port plus the requester/DMAC handshake of the arbiter.
interface dma_req_arbiter_if #(
  parameter int N_REQ = 3,
  parameter int IDX_W = 3
);
  logic              apb_psel;
  logic              apb_penable;
  logic              apb_pwrite;
  logic [11:0]       apb_paddr;
  logic [31:0]       apb_pwdata;
  logic [31:0]       apb_prdata;
  logic [N_REQ-1:0]  req_in;
  logic [N_REQ-1:0]  clr_out;
  logic              dma_breq;
  logic              dma_clr;
  logic              grant_valid;
  logic [IDX_W-1:0]  grant_idx;

  modport slave (
    input  apb_psel, apb_penable, apb_pwrite, apb_paddr, apb_pwdata,
    input  req_in, dma_clr,
    output apb_prdata, clr_out, dma_breq, grant_valid, grant_idx
  );

  modport master (
    output apb_psel, apb_penable, apb_pwrite, apb_paddr, apb_pwdata,
    output req_in, dma_clr,
    input  apb_prdata, clr_out, dma_breq, grant_valid, grant_idx
  );
endinterface

// File: rtl/dma_req_arbiter_rr_pick.sv
// Round-robin search: first set candidate starting just after i_ptr, wrapping.
module dma_req_arbiter_rr_pick #(
  parameter int N_REQ = 3,
  parameter int IDX_W = 3
) (
  input  logic [N_REQ-1:0] i_cand,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  logic [2*N_REQ-1:0] w_dbl;
  logic [2*N_REQ-1:0] w_shifted;
  logic [N_REQ-1:0]   w_rot;

  // Rotating a doubled copy puts candidate (ptr+1+k) mod N at bit k.
  assign w_dbl     = {i_cand, i_cand};
  assign w_shifted = w_dbl >> (int'(i_ptr) + 1);
  assign w_rot     = w_shifted[N_REQ-1:0];

  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        o_idx   = IDX_W'((int'(i_ptr) + 1 + k) % N_REQ);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_req_arbiter.sv
// Shares one DMAC burst-request channel among N_REQ requesters, round-robin,
// with an APB register window for control, status and transfer counting.
module dma_req_arbiter
  import dma_req_arbiter_pkg::*;
#(
  parameter int N_REQ       = 3,
  parameter int IDX_W       = 3,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              apb_clock,
  input  logic              resetn,
  dma_req_arbiter_if.slave  bus
);

  localparam int TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  arb_state_t        r_state;
  arb_state_t        w_state_next;
  logic [N_REQ-1:0]  r_mask;
  logic              r_arb_en;
  logic              r_tmo_err;
  logic [IDX_W-1:0]  r_err_idx;
  logic [IDX_W-1:0]  r_grant_idx;
  logic [IDX_W-1:0]  r_rr_ptr;
  logic [TMO_W-1:0]  r_tmo_cnt;
  logic [XFER_W-1:0] r_xfer_cnt;
  logic [31:0]       r_prdata;

  logic [N_REQ-1:0]  w_cand;
  logic [IDX_W-1:0]  w_pick_idx;
  logic              w_pick_valid;
  logic              w_grant_start;
  logic              w_clr_hit;
  logic              w_timeout;
  logic              w_setup;
  logic              w_wr;
  logic              w_busy;
  logic [31:0]       w_rd_data;

  assign w_cand  = bus.req_in & r_mask;
  assign w_setup = bus.apb_psel & ~bus.apb_penable & ~bus.apb_pwrite;
  assign w_wr    = bus.apb_psel & bus.apb_penable & bus.apb_pwrite;
  assign w_busy  = (r_state == ST_GRANT) || (r_state == ST_CLR);

  dma_req_arbiter_rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr_pick (
    .i_cand  (w_cand),
    .i_ptr   (r_rr_ptr),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  always_ff @(posedge apb_clock or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  // A clear arriving on the timeout cycle wins and is counted as normal.
  always_comb begin
    w_state_next  = r_state;
    w_grant_start = 1'b0;
    w_clr_hit     = 1'b0;
    w_timeout     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_arb_en && w_pick_valid) begin
          w_state_next  = ST_GRANT;
          w_grant_start = 1'b1;
        end
      end
      ST_GRANT: begin
        if (bus.dma_clr) begin
          w_state_next = ST_CLR;
          w_clr_hit    = 1'b1;
        end else if (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
          w_state_next = ST_GAP;
          w_timeout    = 1'b1;
        end
      end
      ST_CLR:  w_state_next = ST_GAP;
      ST_GAP:  w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_rd_data = '0;
    case (bus.apb_paddr)
      ADDR_CTRL: begin
        w_rd_data[N_REQ-1:0]   = r_mask;
        w_rd_data[CTRL_EN_BIT] = r_arb_en;
      end
      ADDR_STAT: begin
        w_rd_data[STAT_BUSY_BIT]               = w_busy;
        w_rd_data[STAT_TMO_BIT]                = r_tmo_err;
        w_rd_data[STAT_GIDX_LSB +: IDX_W]      = r_grant_idx;
        w_rd_data[STAT_EIDX_LSB +: IDX_W]      = r_err_idx;
      end
      ADDR_XFER_CNT: w_rd_data[XFER_W-1:0] = r_xfer_cnt;
      default:       w_rd_data = '0;
    endcase
  end

  always_ff @(posedge apb_clock or negedge resetn) begin
    if (!resetn) begin
      r_mask      <= '0;
      r_arb_en    <= 1'b0;
      r_tmo_err   <= 1'b0;
      r_err_idx   <= '0;
      r_grant_idx <= '0;
      r_rr_ptr    <= '0;
      r_tmo_cnt   <= '0;
      r_xfer_cnt  <= '0;
      r_prdata    <= '0;
    end else begin
      if (w_grant_start) begin
        r_grant_idx <= w_pick_idx;
        r_rr_ptr    <= w_pick_idx;
      end
      r_tmo_cnt <= (r_state == ST_GRANT) ? r_tmo_cnt + TMO_W'(1) : '0;
      if (w_timeout) begin
        r_tmo_err <= 1'b1;
        r_err_idx <= r_grant_idx;
      end else if (w_wr && bus.apb_paddr == ADDR_STAT && bus.apb_pwdata[STAT_TMO_BIT]) begin
        r_tmo_err <= 1'b0;
      end
      if (w_wr && bus.apb_paddr == ADDR_XFER_CNT) r_xfer_cnt <= '0;
      else if (w_clr_hit)                          r_xfer_cnt <= r_xfer_cnt + 16'd1;
      if (w_wr && bus.apb_paddr == ADDR_CTRL) begin
        r_mask   <= bus.apb_pwdata[N_REQ-1:0];
        r_arb_en <= bus.apb_pwdata[CTRL_EN_BIT];
      end
      if (w_setup) r_prdata <= w_rd_data;
    end
  end

  assign bus.dma_breq    = (r_state == ST_GRANT);
  assign bus.grant_valid = w_busy;
  assign bus.grant_idx   = r_grant_idx;
  assign bus.apb_prdata  = r_prdata;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_clr
    assign bus.clr_out[gi] = (r_state == ST_CLR) && (r_grant_idx == IDX_W'(gi));
  end

endmodule
